// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the PC/fetch stage and instruction memory.
// The fetch unit drives the request and address; memory answers with ack and data.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// KGP-miniRISC program counter and instruction-fetch stage.
// Fetches the word at the current PC over a req/ack bus, holds it for decode
// until execute commits, then loads the PC from the jump unit's next_address.
// Also tracks halt, fetch-timeout fault and the retired-instruction count.
// Every output is a register, so no input reaches an output combinationally.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [31:0]          next_address_i,
    input  logic                 commit_i,
    input  logic                 halt_i,
    pc_fetch_unit_if.master      imem,
    output logic [31:0]          pc_out_o,
    output logic [31:0]          instr_o,
    output logic                 instr_valid_o,
    output logic                 halted_o,
    output logic                 fault_o,
    output logic [31:0]          retired_o
);

    // Counter is wide enough to hold TIMEOUT itself.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(0);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    // Value held during the last allowed FETCH cycle: a missing ack there faults.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   retired_q, retired_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          req_q, valid_q, halted_q, fault_q;

    // Next-state and datapath update decoded from the current state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (imem.imem_ack) begin
                    instr_d = imem.imem_data;
                    tmo_d   = TMO_ZERO;
                    state_d = ST_EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = tmo_q + TMO_ONE;
                    state_d = ST_FAULT;
                end else begin
                    tmo_d   = tmo_q + TMO_ONE;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // The PC follows next_address even on HALT so it points past it.
                if (commit_i) begin
                    pc_d      = next_address_i;
                    retired_d = retired_q + 32'd1;
                    if (halt_i) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, datapath and strobe registers; strobes are pre-decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
            tmo_q     <= TMO_ZERO;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
            req_q     <= (state_d == ST_FETCH);
            valid_q   <= (state_d == ST_EXEC);
            halted_q  <= (state_d == ST_HALTED);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc_out_o       = pc_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = valid_q;
    assign halted_o       = halted_q;
    assign fault_o        = fault_q;
    assign retired_o      = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a table of instructions (wait states,
// fetched word, next address, halt) is replayed through fetch/commit with a
// scoreboard of expected instruction words, followed by hand-written sequences
// for timeout, timeout boundary, mid-operation reset and retired-count wrap.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] next_address;
    logic        commit;
    logic        halt;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .next_address_i (next_address),
        .commit_i       (commit),
        .halt_i         (halt),
        .imem           (bus),
        .pc_out_o       (pc_out),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .halted_o       (halted),
        .fault_o        (fault),
        .retired_o      (retired)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef struct {
        int          waits;
        logic [31:0] data;
        logic [31:0] na;
        bit          hlt;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] exp_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " pc_out"},      pc_out, RST_PC);
        chk({tag, " instr"},       instr, 32'h0000_0000);
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, " imem_req"},    {31'd0, bus.imem_req}, 32'd0);
        chk({tag, " imem_addr"},   bus.imem_addr, RST_PC);
        chk({tag, " halted"},      {31'd0, halted}, 32'd0);
        chk({tag, " fault"},       {31'd0, fault}, 32'd0);
        chk({tag, " retired"},     retired, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_pc  = RST_PC;
        m_ret = 32'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Starting in a FETCH cycle: wait states, ack, check EXEC, commit.
    task automatic run_instr(input vec_t v, input string tag);
        logic [31:0] e;
        chk({tag, " fetch addr"}, bus.imem_addr, m_pc);
        for (int w = 0; w < v.waits; w++) begin
            bus.imem_ack = 1'b0;
            tick();
            chk({tag, " req during wait"}, {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = v.data;
        exp_q.push_back(v.data);
        tick();
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0000_0000;
        chk({tag, " req after ack"}, {31'd0, bus.imem_req}, 32'd0);
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd1);
        e = exp_q.pop_front();
        chk({tag, " instr"}, instr, e);
        commit       = 1'b1;
        next_address = v.na;
        halt         = v.hlt;
        tick();
        commit = 1'b0;
        halt   = 1'b0;
        m_pc   = v.na;
        m_ret  = m_ret + 32'd1;
        chk({tag, " pc_out"}, pc_out, m_pc);
        chk({tag, " retired"}, retired, m_ret);
        chk({tag, " valid after commit"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.hlt});
        chk({tag, " req after commit"}, {31'd0, bus.imem_req}, {31'd0, ~v.hlt});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; commit = 1'b0; halt = 1'b0;
        next_address = 32'h0000_0000;
        bus.imem_ack = 1'b0; bus.imem_data = 32'h0000_0000;

        vecs[0] = '{0,  32'hA5A5_0001, 32'h0000_0001, 1'b0};
        vecs[1] = '{3,  32'hDEAD_BEEF, 32'h0000_0040, 1'b0};
        vecs[2] = '{15, 32'h1234_5678, 32'h0000_0041, 1'b0};
        vecs[3] = '{1,  32'h0000_0000, 32'h0000_0042, 1'b0};
        vecs[4] = '{0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[5] = '{2,  32'hCAFE_F00D, 32'h0000_0007, 1'b1};

        // Reset and start
        do_reset();
        check_reset_outputs("reset");
        tick();
        chk("idle req", {31'd0, bus.imem_req}, 32'd0);
        do_start();
        chk("start req", {31'd0, bus.imem_req}, 32'd1);
        chk("start addr", bus.imem_addr, RST_PC);
        chk("start valid", {31'd0, instr_valid}, 32'd0);

        // Instruction table, ending in HALT
        for (int i = 0; i < 6; i++) begin
            run_instr(vecs[i], $sformatf("vec%0d", i));
        end

        // HALTED is terminal: commit/start/ack are ignored
        for (int i = 0; i < 3; i++) begin
            commit = 1'b1; halt = 1'b0; start = 1'b1; bus.imem_ack = 1'b1;
            next_address = 32'h0000_0099;
            tick();
            chk("halted pc", pc_out, 32'h0000_0007);
            chk("halted flag", {31'd0, halted}, 32'd1);
            chk("halted req", {31'd0, bus.imem_req}, 32'd0);
            chk("halted retired", retired, m_ret);
        end
        commit = 1'b0; start = 1'b0; bus.imem_ack = 1'b0;

        // Timeout: no ack for TMO FETCH cycles
        do_reset();
        do_start();
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("tmo fault early", {31'd0, fault}, 32'd0);
            chk("tmo req", {31'd0, bus.imem_req}, 32'd1);
        end
        tick();
        chk("tmo fault", {31'd0, fault}, 32'd1);
        chk("tmo req off", {31'd0, bus.imem_req}, 32'd0);
        start = 1'b1; bus.imem_ack = 1'b1; commit = 1'b1;
        tick();
        tick();
        start = 1'b0; bus.imem_ack = 1'b0; commit = 1'b0;
        chk("fault sticky", {31'd0, fault}, 32'd1);
        chk("fault valid", {31'd0, instr_valid}, 32'd0);

        // Ack on the last allowed FETCH cycle wins
        do_reset();
        do_start();
        for (int i = 1; i < TMO; i++) tick();
        bus.imem_ack = 1'b1; bus.imem_data = 32'h0BAD_F00D;
        tick();
        bus.imem_ack = 1'b0;
        chk("bound fault", {31'd0, fault}, 32'd0);
        chk("bound valid", {31'd0, instr_valid}, 32'd1);
        chk("bound instr", instr, 32'h0BAD_F00D);

        // Reset mid-EXEC (instr non-zero) then mid-FETCH
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst exec");
        do_start();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst fetch");

        // Retired counter wrap
        do_reset();
        do_start();
        bus.imem_ack = 1'b1; bus.imem_data = 32'h1111_2222;
        tick();
        bus.imem_ack = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        tick();
        release dut.retired_q;
        tick();
        chk("wrap preload", retired, 32'hFFFF_FFFF);
        commit = 1'b1; next_address = 32'h0000_0005;
        tick();
        commit = 1'b0;
        chk("wrap retired", retired, 32'h0000_0000);
        chk("wrap pc", pc_out, 32'h0000_0005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of KGP-miniRISC. It sits directly upstream of the jump unit: it drives the current PC into the jump unit's `PCin` and consumes the jump unit's `next_address` when execute commits an instruction. Between commits it runs a request/acknowledge fetch against instruction memory and presents the fetched word to decode. It also provides halt, timeout-fault and retired-instruction tracking.

## Interface
Parameters:
- `RESET_PC`, 32'h0: PC value loaded on reset.
- `TIMEOUT`, 16: number of FETCH cycles without `imem_ack` after which the unit faults (must be ≥1).

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  leaves IDLE and begins fetching.
- `next_address`  in  32  next PC from the jump unit; sampled only on an accepted commit.
- `commit`  in  1  execute has finished the current instruction; `next_address` is valid.
- `halt`  in  1  current instruction is HALT; sampled with `commit`.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc_out` whenever `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_data` this cycle.
- `imem_data`  in  32  instruction word.
- `pc_out`  out  32  current PC; drives the jump unit's `PCin`.
- `instr`  out  32  latched instruction for decode.
- `instr_valid`  out  1  `instr` is valid and awaiting commit.
- `halted`  out  1  unit is in HALTED.
- `fault`  out  1  unit is in FAULT (fetch timeout).
- `retired`  out  32  count of accepted commits.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALTED, FAULT. Reset state is IDLE.
- **IDLE**
  - All strobes are low.
  - `start`=1 moves to FETCH.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=`pc_out`.
  - `imem_ack`=1: latch `imem_data` into `instr`, clear the timeout counter, move to EXEC.
  - Otherwise the timeout counter increments. When the counter reaches `TIMEOUT` with no ack, move to FAULT.
  - An ack arriving in the same cycle the counter reaches `TIMEOUT` wins: the unit goes to EXEC.
- **EXEC**
  - `instr_valid`=1 and `instr` is held stable.
  - `commit`=1 (accepted commit):
    - `pc_out` loads `next_address`.
    - `retired` increments.
    - If `halt`=1, move to HALTED; otherwise move to FETCH.
  - The PC is updated even when `halt`=1.
- **HALTED / FAULT**
  - Terminal states; only `rst` leaves them.
  - `halted` or `fault` respectively is 1; all strobes are low.
- Ignored inputs:
  - `commit` and `halt` outside EXEC.
  - `imem_ack` outside FETCH.
  - `start` outside IDLE.
- Arithmetic:
  - `next_address` is taken verbatim; the PC is word-addressed and the increment is done in the jump unit, not here.
  - `retired` wraps from 32'hFFFFFFFF to 0.
  - The timeout counter is wide enough to hold `TIMEOUT` without overflow.
- Reset values:
  - `pc_out`=`RESET_PC`.
  - `instr`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `halted`=0, `fault`=0, `retired`=0, timeout counter=0.
- Reset asserted in any state, including mid-fetch, returns every register to its reset value at the next edge. An outstanding memory request is abandoned.

## Timing
- `start` sampled high at edge N: `imem_req`=1 from cycle N+1.
- `imem_ack` sampled high at edge M: `instr` and `instr_valid`=1 from cycle M+1; `imem_req`=0 from M+1.
- An ack in the first FETCH cycle is legal (zero wait states).
- Accepted `commit` at edge K: the new `pc_out` and `imem_req`=1 with the new `imem_addr` from cycle K+1; `instr_valid`=0 from cycle K+1.
- Minimum throughput is 2 cycles per instruction (one FETCH cycle plus one EXEC cycle).
- `instr_valid` and `imem_req` are never high in the same cycle.
- Fault timing: with no ack, the FETCH cycle in which the timeout counter reaches `TIMEOUT` is its last; FAULT is entered at the following edge and `fault`=1 from then on.
- All outputs are registered or decoded from FSM state only; there is no combinational path from any input to any output.

## Test plan
- **Reset and start:** `rst` high for 2 cycles, then `start` pulse → `pc_out`=`RESET_PC`=0, `imem_req`=1 with `imem_addr`=0 the cycle after `start`; all other outputs at their reset values.
- **Zero-wait sequential fetch:** ack on the first FETCH cycle with `imem_data`=32'hA5A5_0001; commit with `next_address`=1 → `instr`=32'hA5A5_0001, `instr_valid` high for 1 cycle, next `imem_addr`=1, `retired`=1.
- **Branch with wait states:** ack 3 cycles late, then commit with `next_address`=32'h40 → `imem_req` stays high for 4 cycles; next fetch is at 32'h40.
- **Halt:** commit with `halt`=1 and `next_address`=7 → `pc_out`=7, `halted`=1, `imem_req` stays 0; further `commit`/`start` have no effect.
- **Timeout:** `TIMEOUT`=16, never ack → `fault`=1 after the 16th FETCH cycle.
- **Ack on the timeout boundary:** ack on the 16th FETCH cycle → EXEC entered, `fault` stays 0.
- **Mid-operation reset:** `rst` asserted mid-FETCH and mid-EXEC → all outputs return to reset values one edge later.
- **Counter wrap:** preload `retired`=32'hFFFFFFFF, then one commit → `retired`=0.
